// File: rtl/count_sched.sv
// rtl/count_sched.sv - round-robin scheduler sharing one loadable up-counter
module count_sched #(
  parameter int NREQ = 4,
  parameter int W    = 8
) (
  input  logic              clk,
  input  logic              res,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ*W-1:0] req_len,
  output logic [NREQ-1:0]   gnt,
  output logic [NREQ-1:0]   done,
  output logic              busy,
  output logic              cnt_load,
  output logic              cnt_en,
  output logic [W-1:0]      cnt_in,
  input  logic [W-1:0]      cnt
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t          state, state_nxt;
  logic [IW-1:0]   ptr, ptr_nxt;
  logic [IW-1:0]   gidx, gidx_nxt;
  logic [W-1:0]    len_reg, len_nxt;
  logic [NREQ-1:0] gnt_nxt, done_nxt;

  logic            hi_ok, lo_ok, pick_ok;
  logic [IW-1:0]   hi_idx, lo_idx, pick_idx;
  logic [W-1:0]    pick_len;
  logic [IW-1:0]   ptr_after;
  logic            abort;

  // Round-robin pick: lowest set bit at or above ptr, else lowest set bit overall
  always_comb begin
    hi_ok  = 1'b0;
    lo_ok  = 1'b0;
    hi_idx = '0;
    lo_idx = '0;
    for (int j = NREQ - 1; j >= 0; j--) begin
      if (req[j]) begin
        lo_ok  = 1'b1;
        lo_idx = IW'(j);
      end
      if (req[j] && (IW'(j) >= ptr)) begin
        hi_ok  = 1'b1;
        hi_idx = IW'(j);
      end
    end
    pick_ok  = hi_ok | lo_ok;
    pick_idx = hi_ok ? hi_idx : lo_idx;
  end

  // Length slice of the winning requester
  always_comb begin
    pick_len = '0;
    for (int j = 0; j < NREQ; j++) begin
      if (IW'(j) == pick_idx) pick_len = req_len[j*W +: W];
    end
  end

  assign ptr_after = (gidx == IW'(NREQ - 1)) ? '0 : gidx + 1'b1;
  assign abort     = ((req & gnt) == '0);

  // Next-state and next-register values; done is a one-cycle copy of gnt
  always_comb begin
    state_nxt = state;
    gnt_nxt   = gnt;
    done_nxt  = '0;
    len_nxt   = len_reg;
    ptr_nxt   = ptr;
    gidx_nxt  = gidx;
    case (state)
      IDLE: begin
        if (pick_ok) begin
          gnt_nxt   = NREQ'(1) << pick_idx;
          gidx_nxt  = pick_idx;
          len_nxt   = pick_len;
          state_nxt = LOAD;
        end
      end
      LOAD: begin
        if (abort) begin
          gnt_nxt   = '0;
          ptr_nxt   = ptr_after;
          state_nxt = IDLE;
        end else begin
          state_nxt = RUN;
        end
      end
      RUN: begin
        if (abort) begin
          gnt_nxt   = '0;
          ptr_nxt   = ptr_after;
          state_nxt = IDLE;
        end else if (cnt == len_reg) begin
          done_nxt  = gnt;
          state_nxt = DONE;
        end
      end
      DONE: begin
        gnt_nxt   = '0;
        ptr_nxt   = ptr_after;
        state_nxt = IDLE;
      end
      default: begin
        gnt_nxt   = '0;
        state_nxt = IDLE;
      end
    endcase
  end

  // State and registered outputs; reset aborts any job without a done pulse
  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      state   <= IDLE;
      ptr     <= '0;
      gidx    <= '0;
      len_reg <= '0;
      gnt     <= '0;
      done    <= '0;
    end else begin
      state   <= state_nxt;
      ptr     <= ptr_nxt;
      gidx    <= gidx_nxt;
      len_reg <= len_nxt;
      gnt     <= gnt_nxt;
      done    <= done_nxt;
    end
  end

  assign busy     = (state != IDLE);
  assign cnt_load = (state == LOAD);
  assign cnt_en   = (state == RUN) && (cnt != len_reg);
  assign cnt_in   = '0;

endmodule

// File: tb/tb_count_sched.sv
// tb/tb_count_sched.sv - self-checking bench for count_sched with a behavioural counter
module tb_count_sched;

  localparam int NREQ = 4;
  localparam int W    = 8;

  logic              clk = 1'b0;
  logic              res = 1'b0;
  logic [NREQ-1:0]   req = '0;
  logic [NREQ*W-1:0] req_len = '0;
  logic [NREQ-1:0]   gnt, done;
  logic              busy, cnt_load, cnt_en;
  logic [W-1:0]      cnt_in;
  logic [W-1:0]      cnt = '0;

  int checks = 0;
  int errors = 0;
  int mptr   = 0;

  count_sched #(.NREQ(NREQ), .W(W)) dut (
    .clk(clk), .res(res), .req(req), .req_len(req_len),
    .gnt(gnt), .done(done), .busy(busy),
    .cnt_load(cnt_load), .cnt_en(cnt_en), .cnt_in(cnt_in), .cnt(cnt)
  );

  always #5 clk = ~clk;

  // Shared count8-style counter: load has priority over enable
  always @(posedge clk) begin
    if (cnt_load) cnt <= cnt_in;
    else if (cnt_en) cnt <= cnt + 1'b1;
  end

  // Reference arbitration: first requester at or after the pointer, wrapping
  function automatic int pick(logic [NREQ-1:0] r, int p);
    for (int i = 0; i < NREQ; i++)
      if (r[(p + i) % NREQ]) return (p + i) % NREQ;
    return -1;
  endfunction

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    res = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (gnt !== '0) begin errors++; $display("FAIL rst_gnt: got %b want 0", gnt); end
    checks++; if (done !== '0) begin errors++; $display("FAIL rst_done: got %b want 0", done); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b want 0", busy); end
    checks++; if (cnt_load !== 1'b0) begin errors++; $display("FAIL rst_load: got %b want 0", cnt_load); end
    checks++; if (cnt_en !== 1'b0) begin errors++; $display("FAIL rst_en: got %b want 0", cnt_en); end
    checks++; if (cnt_in !== '0) begin errors++; $display("FAIL rst_cnt_in: got %h want 0", cnt_in); end
    res  = 1'b1;
    mptr = 0;
    tick();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL idle_busy: got %b want 0", busy); end
  endtask

  task automatic test_round_robin();
    logic [NREQ-1:0] eg;
    int idx;
    for (int i = 0; i < NREQ; i++) req_len[i*W +: W] = 8'd1;
    req = '1;
    for (int n = 0; n < 5; n++) begin
      idx = pick(req, mptr);
      eg  = NREQ'(1) << idx;
      tick();
      checks++; if (gnt !== eg) begin errors++; $display("FAIL rr_gnt[%0d]: got %b want %b", n, gnt, eg); end
      tick();
      tick();
      tick();
      checks++; if (done !== eg) begin errors++; $display("FAIL rr_done[%0d]: got %b want %b", n, done, eg); end
      if (n == 4) req = '0;
      tick();
      checks++; if (busy !== 1'b0 || gnt !== '0) begin errors++; $display("FAIL rr_idle[%0d]: busy %b gnt %b want 0 0", n, busy, gnt); end
      mptr = (idx + 1) % NREQ;
    end
  endtask

  task automatic test_single();
    req_len[0 +: W] = 8'd3;
    req = 4'b0001;
    tick();
    checks++; if (gnt !== 4'b0001) begin errors++; $display("FAIL single_gnt: got %b want 0001", gnt); end
    checks++; if (cnt_load !== 1'b1 || busy !== 1'b1) begin errors++; $display("FAIL single_load: load %b busy %b want 1 1", cnt_load, busy); end
    for (int k = 0; k <= 3; k++) begin
      tick();
      checks++; if (cnt !== W'(k)) begin errors++; $display("FAIL single_cnt: got %0d want %0d", cnt, k); end
      checks++; if (cnt_en !== (k != 3) || done !== '0) begin errors++; $display("FAIL single_run: en %b done %b at k=%0d", cnt_en, done, k); end
    end
    tick();
    checks++; if (done !== 4'b0001 || gnt !== 4'b0001) begin errors++; $display("FAIL single_done: done %b gnt %b want 0001 0001", done, gnt); end
    req = '0;
    tick();
    checks++; if (busy !== 1'b0 || done !== '0 || gnt !== '0) begin errors++; $display("FAIL single_end: busy %b done %b gnt %b want 0", busy, done, gnt); end
    mptr = 1;
  endtask

  task automatic test_zero_len();
    req_len[1*W +: W] = 8'd0;
    req = 4'b0010;
    tick();
    checks++; if (gnt !== 4'b0010) begin errors++; $display("FAIL zero_gnt: got %b want 0010", gnt); end
    tick();
    checks++; if (cnt !== '0 || cnt_en !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL zero_run: cnt %0d en %b busy %b want 0 0 1", cnt, cnt_en, busy); end
    tick();
    checks++; if (done !== 4'b0010) begin errors++; $display("FAIL zero_done: got %b want 0010", done); end
    req = '0;
    tick();
    checks++; if (cnt !== '0 || busy !== 1'b0) begin errors++; $display("FAIL zero_end: cnt %0d busy %b want 0 0", cnt, busy); end
    mptr = 2;
  endtask

  task automatic test_abort();
    req_len[2*W +: W] = 8'd10;
    req_len[0 +: W]   = 8'd1;
    req = 4'b0100;
    tick();
    checks++; if (gnt !== 4'b0100) begin errors++; $display("FAIL abort_gnt: got %b want 0100", gnt); end
    for (int k = 0; k <= 4; k++) begin
      tick();
      checks++; if (cnt !== W'(k) || done !== '0) begin errors++; $display("FAIL abort_run: cnt %0d done %b want %0d 0", cnt, done, k); end
    end
    req = 4'b0001;
    tick();
    checks++; if (busy !== 1'b0 || gnt !== '0 || done !== '0) begin errors++; $display("FAIL abort_idle: busy %b gnt %b done %b want 0", busy, gnt, done); end
    checks++; if (cnt !== 8'd5) begin errors++; $display("FAIL abort_cnt_hold: got %0d want 5", cnt); end
    mptr = 3;
    tick();
    checks++; if (gnt !== NREQ'(1) << pick(req, mptr)) begin errors++; $display("FAIL abort_next_gnt: got %b want 0001", gnt); end
    tick();
    tick();
    tick();
    checks++; if (done !== 4'b0001) begin errors++; $display("FAIL abort_next_done: got %b want 0001", done); end
    req = '0;
    tick();
    mptr = 1;
  endtask

  task automatic test_async_reset();
    req_len[0 +: W] = 8'd8;
    req = 4'b0001;
    tick();
    for (int k = 0; k <= 5; k++) tick();
    checks++; if (cnt !== 8'd5) begin errors++; $display("FAIL areset_pre_cnt: got %0d want 5", cnt); end
    #2 res = 1'b0;
    #1;
    checks++; if (gnt !== '0 || busy !== 1'b0 || cnt_en !== 1'b0 || done !== '0) begin
      errors++; $display("FAIL areset_async: gnt %b busy %b en %b done %b want 0", gnt, busy, cnt_en, done);
    end
    @(negedge clk);
    req = 4'b0011;
    req_len[0 +: W] = 8'd2;
    req_len[1*W +: W] = 8'd7;
    res = 1'b1;
    mptr = 0;
    tick();
    checks++; if (gnt !== NREQ'(1) << pick(req, mptr)) begin errors++; $display("FAIL areset_ptr: got %b want 0001", gnt); end
    for (int k = 0; k <= 2; k++) begin
      tick();
      checks++; if (cnt !== W'(k)) begin errors++; $display("FAIL areset_cnt: got %0d want %0d", cnt, k); end
    end
    tick();
    checks++; if (done !== 4'b0001) begin errors++; $display("FAIL areset_done: got %b want 0001", done); end
    req = '0;
    tick();
    mptr = 1;
  endtask

  task automatic test_len_change();
    req_len[0 +: W] = 8'd4;
    req = 4'b0001;
    tick();
    for (int k = 0; k <= 4; k++) begin
      tick();
      if (k == 1) req_len[0 +: W] = 8'd9;
      checks++; if (cnt !== W'(k) || cnt_en !== (k != 4)) begin errors++; $display("FAIL lenchg_run: cnt %0d en %b at k=%0d", cnt, cnt_en, k); end
    end
    tick();
    checks++; if (done !== 4'b0001 || cnt !== 8'd4) begin errors++; $display("FAIL lenchg_done: done %b cnt %0d want 0001 4", done, cnt); end
    req = '0;
    tick();
    mptr = 1;
  endtask

  task automatic test_random();
    for (int n = 0; n < 24; n++) begin
      logic [NREQ-1:0] mask, eg;
      logic [W-1:0] l;
      int idx;
      mask = NREQ'($urandom_range(1, (1 << NREQ) - 1));
      for (int i = 0; i < NREQ; i++) req_len[i*W +: W] = W'($urandom_range(0, 12));
      idx = pick(mask, mptr);
      eg  = NREQ'(1) << idx;
      l   = req_len[idx*W +: W];
      req = mask;
      tick();
      checks++; if (gnt !== eg || cnt_load !== 1'b1) begin errors++; $display("FAIL rand_gnt[%0d]: gnt %b load %b want %b 1", n, gnt, cnt_load, eg); end
      for (int k = 0; k <= int'(l); k++) begin
        tick();
        if ($urandom_range(0, 1) == 1) req_len = (NREQ*W)'($urandom());
        checks++; if (cnt !== W'(k) || cnt_en !== (k != int'(l)) || gnt !== eg || done !== '0) begin
          errors++; $display("FAIL rand_run[%0d]: cnt %0d en %b gnt %b done %b want %0d %b %b 0", n, cnt, cnt_en, gnt, done, k, (k != int'(l)), eg);
        end
      end
      tick();
      checks++; if (done !== eg || gnt !== eg) begin errors++; $display("FAIL rand_done[%0d]: done %b gnt %b want %b", n, done, gnt, eg); end
      tick();
      checks++; if (busy !== 1'b0 || gnt !== '0 || done !== '0) begin errors++; $display("FAIL rand_idle[%0d]: busy %b gnt %b done %b want 0", n, busy, gnt, done); end
      mptr = (idx + 1) % NREQ;
    end
    req = '0;
    tick();
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_single();
    test_zero_len();
    test_abort();
    test_async_reset();
    test_len_change();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/count_sched.md
Name: count_sched

Overview:
- Round-robin scheduler that shares one 8-bit loadable up-counter (count8-style ports: synchronous load with priority over enable, +1 per enabled clock, wraps at 8'hFF) among NREQ requesters.
- Each requester asks for a timed interval of `len` counts.
- The scheduler grants one requester at a time, loads the counter with zero, enables it until the count equals `len`, then pulses that requester's done line.
- Sits between the requesting blocks and the shared counter instance; drives the counter's `load`, `EN` and `CNT_In`, and observes its `CNT`.

Parameters:
- NREQ, 4, number of requesters (2..8)
- W, 8, counter/interval width; must match the counter

Ports:
- clk      input   1        system clock, rising edge
- res      input   1        asynchronous active-low reset
- req      input   NREQ     level request per requester; held until done
- req_len  input   NREQ*W   interval length per requester; slice i = req_len[i*W +: W]
- gnt      output  NREQ     one-hot grant, registered
- done     output  NREQ     one-cycle completion pulse for the granted requester
- busy     output  1        high whenever state != IDLE
- cnt_load output  1        to counter `load`
- cnt_en   output  1        to counter `EN`
- cnt_in   output  W        to counter `CNT_In`; constant 0
- cnt      input   W        from counter `CNT`

Behaviour:
- Reset (res=0, asynchronous):
  - state=IDLE, rr pointer=0, len_reg=0.
  - gnt, done, busy, cnt_load and cnt_en all 0; cnt_in=0.
  - Reset asserted mid-operation aborts immediately; no done is issued.
- States are IDLE, LOAD, RUN and DONE. cnt_load, cnt_en and busy are decoded from the state register; gnt, done and len_reg are registered.
- IDLE:
  - If any req bit is 1, pick the first set bit searching from pointer upward, wrapping modulo NREQ.
  - Set gnt to that one-hot, latch len_reg from that requester's req_len slice, go to LOAD.
  - If no req bit is set, stay in IDLE.
- LOAD (one cycle):
  - cnt_load=1, cnt_en=0; the counter becomes 0 at the closing edge.
  - Next state RUN.
- RUN:
  - cnt_en = (cnt != len_reg).
  - When cnt == len_reg, go to DONE.
  - This takes len_reg+1 RUN cycles; len_reg=0 gives one RUN cycle with cnt_en=0.
  - The counter holds the value len_reg afterwards.
- DONE (one cycle):
  - done = gnt (single pulse); gnt is still asserted.
  - Next state IDLE, with gnt cleared on entry to IDLE.
  - pointer = (granted index + 1) mod NREQ.
- Latency: a request sampled in IDLE cycle T gives LOAD at T+1, RUN at T+2..T+2+len, and the done pulse at T+3+len.
- Abort:
  - If the granted requester's req drops during LOAD or RUN, go to IDLE next cycle with no done.
  - gnt is cleared and the pointer advances as for DONE.
  - The counter is left at its current value.
- req_len changes after the grant are ignored; len_reg is stable until the next grant.
- Requests from non-granted requesters during LOAD, RUN or DONE are ignored until IDLE.
  - Arbitration always spends one IDLE cycle between jobs, so back-to-back jobs are separated by exactly one IDLE cycle.
- A requester still holding req after its done is re-granted only in its round-robin turn.
- Wrap-around: the count never exceeds len_reg ≤ 2^W−1, so the counter never wraps while scheduled.
- Illegal or unused state encodings return to IDLE.

Test Plan:
- Reset then single request: res low, then high; req=0001, req_len[0]=3 → gnt=0001 from LOAD. cnt seen in RUN is 0,1,2,3; done=0001 exactly one cycle, 6 cycles after the IDLE sample; busy falls with done.
- Zero length: req=0010, len=0 → LOAD, one RUN cycle with cnt_en=0, then done=0010; cnt stays 0.
- Round-robin fairness: req=1111 held, all len=1 → grants in order 0001, 0010, 0100, 1000, 0001. Each done is followed by one IDLE cycle.
- Abort: req=0100, len=10; drop req[2] when cnt=4 → next cycle IDLE, gnt=0, done never pulses. A pending req=0001 is granted after the IDLE cycle, because the pointer is now 3 and wraps to 0.
- Async reset mid-RUN: res=0 while cnt=5 and len=8 → gnt, busy and cnt_en go to 0 without a clock edge, no done. After release with req=0001, len=2, the pointer restarts at 0 and timing is normal.
- Length change after grant: req=0001, len=4; change req_len[0] to 9 during RUN → done still fires when cnt=4.
